arith_problem_source: RTL and testbench

//  Producer end of the problem/answer interface consumed by the alarm-disarm FSM.
//  - Draws pseudo-random arithmetic problems (num1, op, num2) from a free-running LFSR.
//  - Computes each problem's 8-bit answer and presents it with a ready/take handshake.
//  - Answer range 0..255, so it can be entered on the 8-bit DIP switch.

---
 rtl/arith_problem_source_pkg.sv | 45 ++++
 rtl/arith_problem_source_mul4.sv | 51 +++++
 rtl/arith_problem_source.sv | 172 +++++++++++++++++
 tb/tb_arith_problem_source.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_problem_source_pkg.sv
// Shared definitions for the problem/answer interface (op codes, LFSR polynomial, FSM states).
// Latency: n/a (package only).
// Backpressure: n/a.
package arith_problem_source_pkg;

    // Op codes shared with the alarm FSM and the text LCD controller
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;

    // Galois feedback taps, right-shifting register
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef enum logic [1:0] {
        ST_DRAW   = 2'd0,
        ST_MUL    = 2'd1,
        ST_FINISH = 2'd2,
        ST_READY  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] num1;
        logic [7:0] num2;
        logic [2:0] op;
        logic [7:0] answer;
    } problem_t;

    // One Galois step with user entropy folded into the feedback bit.
    // An all-zero result would lock the register, so the seed is reloaded instead.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur,
                                              input logic        ent,
                                              input logic [15:0] seed);
        logic [15:0] nx;
        nx = {1'b0, cur[15:1]};
        if (cur[0] ^ ent) begin
            nx = nx ^ LFSR_POLY;
        end
        if (nx == 16'h0000) begin
            nx = seed;
        end
        return nx;
    endfunction

endpackage

// File: rtl/arith_problem_source_mul4.sv
// 4x4 unsigned shift-add multiplier, one partial product per cycle.
// Latency: start loads operands; 4 iterations follow, done marks the last one, product final the cycle after done.
// Backpressure: none; a new start simply restarts the operation.
module shift_add_mul4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic       done,
    output logic [7:0] product
);

    logic [7:0] mcand;
    logic [3:0] mplier;
    logic [7:0] acc;
    logic [1:0] cnt;
    logic       busy;

    // Load on start, then add the shifted multiplicand for each set multiplier bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= 8'd0;
            mplier <= 4'd0;
            acc    <= 8'd0;
            cnt    <= 2'd0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {4'd0, x};
            mplier <= y;
            acc    <= 8'd0;
            cnt    <= 2'd0;
            busy   <= 1'b1;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= {mcand[6:0], 1'b0};
            mplier <= {1'b0, mplier[3:1]};
            cnt    <= cnt + 2'd1;
            if (cnt == 2'd3) begin
                busy <= 1'b0;
            end
        end
    end

    // done flags the final iteration so the caller can advance on the same edge it completes
    assign done    = busy && (cnt == 2'd3);
    assign product = acc;

endmodule

// File: rtl/arith_problem_source.sv
// Draws random 8-bit arithmetic problems from a free-running LFSR and publishes them with their answer.
// Latency: add/sub 2 cycles, mul/div 6 cycles after reset release or take, +1 per redraw.
// Backpressure: a published problem is held (ready=1) until take; take while ready=0 is ignored.
module arith_problem_source
    import arith_problem_source_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [3:0]  OP_MASK   = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       take,
    input  logic       entropy_in,
    output logic       ready,
    output logic [7:0] num1,
    output logic [7:0] num2,
    output logic [2:0] op,
    output logic [7:0] answer,
    output logic [7:0] problem_id
);

    // A zero seed would never leave zero; an empty mask would never publish
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [3:0]  MASK_EFF = (OP_MASK == 4'b0000) ? 4'b0001 : OP_MASK;

    logic [15:0] lfsr;
    state_t      state, state_nxt;

    logic [1:0]  sel, sel_q;
    logic [6:0]  a, b, a_q, b_q;
    logic [3:0]  y, y_q;
    logic        draw_ok;
    logic        mul_start, mul_done;
    logic [7:0]  mul_product;

    problem_t    prob_q, prob_nxt;
    logic [7:0]  pid_q;
    logic        ready_q;

    assign sel     = lfsr[1:0];
    assign a       = lfsr[8:2];
    assign b       = lfsr[15:9];
    assign draw_ok = MASK_EFF[sel];
    // Divisor must be non-zero; multiply uses b[3:0] unchanged
    assign y       = ((sel == OP_DIV[1:0]) && (b[3:0] == 4'd0)) ? 4'd1 : b[3:0];
    // Mul and div both need x*y: for div it rebuilds the dividend from quotient and divisor
    assign mul_start = (state == ST_DRAW) && draw_ok && sel[1];

    shift_add_mul4 u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .x       (a[3:0]),
        .y       (y),
        .done    (mul_done),
        .product (mul_product)
    );

    // Free-running LFSR, steps every cycle regardless of FSM state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= lfsr_next(lfsr, entropy_in, SEED_EFF);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_DRAW;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: redraw until an enabled op appears, detour through MUL for mul/div
    always_comb begin
        state_nxt = state;
        case (state)
            ST_DRAW: begin
                if (draw_ok) begin
                    state_nxt = sel[1] ? ST_MUL : ST_FINISH;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: state_nxt = ST_READY;
            ST_READY: begin
                if (take) begin
                    state_nxt = ST_DRAW;
                end
            end
            default: state_nxt = ST_DRAW;
        endcase
    end

    // Capture the accepted draw so the LFSR can keep running while the problem is finished
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= 2'd0;
            a_q   <= 7'd0;
            b_q   <= 7'd0;
            y_q   <= 4'd0;
        end else if ((state == ST_DRAW) && draw_ok) begin
            sel_q <= sel;
            a_q   <= a;
            b_q   <= b;
            y_q   <= y;
        end
    end

    // Form the published problem from the captured draw; all results fit in 8 bits by construction
    always_comb begin
        prob_nxt    = '0;
        prob_nxt.op = {1'b0, sel_q};
        case (sel_q)
            2'd0: begin
                prob_nxt.num1   = {1'b0, a_q};
                prob_nxt.num2   = {1'b0, b_q};
                prob_nxt.answer = {1'b0, a_q} + {1'b0, b_q};
            end
            2'd1: begin
                if (a_q >= b_q) begin
                    prob_nxt.num1   = {1'b0, a_q};
                    prob_nxt.num2   = {1'b0, b_q};
                    prob_nxt.answer = {1'b0, a_q} - {1'b0, b_q};
                end else begin
                    prob_nxt.num1   = {1'b0, b_q};
                    prob_nxt.num2   = {1'b0, a_q};
                    prob_nxt.answer = {1'b0, b_q} - {1'b0, a_q};
                end
            end
            2'd2: begin
                prob_nxt.num1   = {4'd0, a_q[3:0]};
                prob_nxt.num2   = {4'd0, y_q};
                prob_nxt.answer = mul_product;
            end
            default: begin
                prob_nxt.num1   = mul_product;
                prob_nxt.num2   = {4'd0, y_q};
                prob_nxt.answer = {4'd0, a_q[3:0]};
            end
        endcase
    end

    // Output registers: load on FINISH, drop only ready on take so operands stay visible
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prob_q  <= '0;
            pid_q   <= 8'd0;
            ready_q <= 1'b0;
        end else if (state == ST_FINISH) begin
            prob_q  <= prob_nxt;
            pid_q   <= pid_q + 8'd1;
            ready_q <= 1'b1;
        end else if ((state == ST_READY) && take) begin
            ready_q <= 1'b0;
        end
    end

    assign ready      = ready_q;
    assign num1       = prob_q.num1;
    assign num2       = prob_q.num2;
    assign op         = prob_q.op;
    assign answer     = prob_q.answer;
    assign problem_id = pid_q;

endmodule

// File: tb/tb_arith_problem_source.sv
// Bench: six problem sources with different op masks/seeds against a problem-level model.
// Latency: n/a.
// Backpressure: take and entropy driven from the bench.
module tb_arith_problem_source;

    localparam int NI = 6;
    // inst0=add, inst1=sub, inst2=mul, inst3=div, inst4=empty mask, inst5=all ops with zero seed
    localparam logic [23:0] MASKS = {4'b1111, 4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    localparam logic [95:0] SEEDS = {16'h0000, 16'hACE1, 16'hACE1, 16'hACE1, 16'hACE1, 16'hACE1};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic take = 1'b0;
    logic entropy_in = 1'b0;

    always #5 clk = ~clk;

    logic        d_ready [NI];
    logic [7:0]  d_num1  [NI];
    logic [7:0]  d_num2  [NI];
    logic [2:0]  d_op    [NI];
    logic [7:0]  d_ans   [NI];
    logic [7:0]  d_pid   [NI];
    logic [15:0] d_lfsr  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic       r_w;
        logic [7:0] n1_w, n2_w, an_w, pid_w;
        logic [2:0] op_w;

        arith_problem_source #(
            .LFSR_SEED (SEEDS[g*16 +: 16]),
            .OP_MASK   (MASKS[g*4 +: 4])
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .take       (take),
            .entropy_in (entropy_in),
            .ready      (r_w),
            .num1       (n1_w),
            .num2       (n2_w),
            .op         (op_w),
            .answer     (an_w),
            .problem_id (pid_w)
        );

        assign d_ready[g] = r_w;
        assign d_num1[g]  = n1_w;
        assign d_num2[g]  = n2_w;
        assign d_op[g]    = op_w;
        assign d_ans[g]   = an_w;
        assign d_pid[g]   = pid_w;
        assign d_lfsr[g]  = u_dut.lfsr;
    end

    // Model state per instance: mode 0 = drawing, 1 = computing (countdown), 2 = published
    int mask_e [NI];
    int seed_e [NI];
    int m_lfsr [NI];
    int m_mode [NI];
    int m_cd   [NI];
    int p_n1 [NI], p_n2 [NI], p_op [NI], p_ans [NI];
    int e_ready [NI], e_n1 [NI], e_n2 [NI], e_op [NI], e_ans [NI], e_pid [NI];
    int prev_pid [NI];
    int wrap_seen [NI];
    int first_rdy [NI];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int inst, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got %0d, expected %0d", nm, inst, $time, act, exp_v);
        end
    endtask

    task automatic model_reset(input int i);
        m_lfsr[i]  = seed_e[i];
        m_mode[i]  = 0;
        m_cd[i]    = 0;
        e_ready[i] = 0;
        e_n1[i]    = 0;
        e_n2[i]    = 0;
        e_op[i]    = 0;
        e_ans[i]   = 0;
        e_pid[i]   = 0;
    endtask

    // One clock of the problem-level behaviour, using the input values present at the edge
    task automatic model_step(input int i);
        int sel, a, b, x, d, fb, nx;
        sel = m_lfsr[i] % 4;
        a   = (m_lfsr[i] / 4) % 128;
        b   = (m_lfsr[i] / 512) % 128;
        if (m_mode[i] == 0) begin
            if (((mask_e[i] >> sel) % 2) == 1) begin
                p_op[i] = sel;
                x = a % 16;
                d = b % 16;
                case (sel)
                    0: begin p_n1[i] = a; p_n2[i] = b; p_ans[i] = a + b; end
                    1: begin
                        p_n1[i] = (a > b) ? a : b;
                        p_n2[i] = (a > b) ? b : a;
                        p_ans[i] = p_n1[i] - p_n2[i];
                    end
                    2: begin p_n1[i] = x; p_n2[i] = d; p_ans[i] = x * d; end
                    default: begin
                        if (d == 0) d = 1;
                        p_n1[i] = x * d; p_n2[i] = d; p_ans[i] = x;
                    end
                endcase
                m_cd[i]   = (sel < 2) ? 1 : 5;
                m_mode[i] = 1;
            end
        end else if (m_mode[i] == 1) begin
            m_cd[i]--;
            if (m_cd[i] == 0) begin
                e_n1[i] = p_n1[i]; e_n2[i] = p_n2[i]; e_op[i] = p_op[i]; e_ans[i] = p_ans[i];
                e_ready[i] = 1;
                e_pid[i]   = (e_pid[i] + 1) % 256;
                m_mode[i]  = 2;
            end
        end else begin
            if (take) begin
                e_ready[i] = 0;
                m_mode[i]  = 0;
            end
        end
        fb = (m_lfsr[i] % 2) ^ int'(entropy_in);
        nx = m_lfsr[i] / 2;
        if (fb == 1) nx = nx ^ 32'h0000_B400;
        if (nx == 0) nx = seed_e[i];
        m_lfsr[i] = nx;
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            chk("ready",  i, int'(d_ready[i]), e_ready[i]);
            chk("num1",   i, int'(d_num1[i]),  e_n1[i]);
            chk("num2",   i, int'(d_num2[i]),  e_n2[i]);
            chk("op",     i, int'(d_op[i]),    e_op[i]);
            chk("answer", i, int'(d_ans[i]),   e_ans[i]);
            chk("pid",    i, int'(d_pid[i]),   e_pid[i]);
            chk("lfsr",   i, int'(d_lfsr[i]),  m_lfsr[i]);
            chk("lfsr_nz", i, int'(d_lfsr[i] != 16'h0000), 1);
            if (prev_pid[i] == 255 && d_pid[i] == 8'd0) wrap_seen[i] = 1;
            prev_pid[i] = int'(d_pid[i]);
        end
    endtask

    task automatic pin(input int i, input int fr, input int n1, input int n2,
                       input int opc, input int ans, input int pid);
        chk("pin_first_ready", i, first_rdy[i], fr);
        chk("pin_num1",        i, int'(d_num1[i]), n1);
        chk("pin_num2",        i, int'(d_num2[i]), n2);
        chk("pin_op",          i, int'(d_op[i]),   opc);
        chk("pin_answer",      i, int'(d_ans[i]),  ans);
        chk("pin_pid",         i, int'(d_pid[i]),  pid);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            mask_e[i] = int'(MASKS[i*4 +: 4]);
            if (mask_e[i] == 0) mask_e[i] = 1;
            seed_e[i] = int'(SEEDS[i*16 +: 16]);
            if (seed_e[i] == 0) seed_e[i] = 1;
            prev_pid[i]  = 0;
            wrap_seen[i] = 0;
            first_rdy[i] = 0;
            model_reset(i);
        end

        fork
            forever begin
                @(posedge clk or negedge rst);
                for (int i = 0; i < NI; i++) begin
                    if (!rst) model_reset(i);
                    else      model_step(i);
                end
            end
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none

        // Deterministic start: entropy held low, hand-derived first problems
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) if (first_rdy[i] == 0 && d_ready[i]) first_rdy[i] = c;
        end
        pin(1, 2,  86,  56, 1,  30, 1);
        pin(0, 3,  28, 113, 0, 141, 1);
        pin(4, 3,  28, 113, 0, 141, 1);
        pin(2, 10,  3,  14, 2,  42, 1);
        pin(3, 11, 63,   7, 3,   9, 1);
        pin(5, 2,   0,   0, 1,   0, 1);

        // Consume, then reset while the mul source is mid-problem
        @(negedge clk); take = 1'b1;
        @(negedge clk); take = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_ready",  2, int'(d_ready[2]), 0);
        chk("rst_pid",    2, int'(d_pid[2]),   0);
        chk("rst_num1",   2, int'(d_num1[2]),  0);
        chk("rst_num2",   2, int'(d_num2[2]),  0);
        chk("rst_answer", 2, int'(d_ans[2]),   0);
        chk("rst_op",     2, int'(d_op[2]),    0);

        // Restart; take pulses while mul/div are still drawing/computing must be ignored
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < NI; i++) first_rdy[i] = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) if (first_rdy[i] == 0 && d_ready[i]) first_rdy[i] = c;
            take = (c >= 3 && c <= 5);
        end
        take = 1'b0;
        pin(2, 10,  3, 14, 2, 42, 1);
        pin(3, 11, 63,  7, 3,  9, 1);

        // Random takes and entropy, with occasional resets
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            take       = ($urandom_range(0, 1) == 1);
            entropy_in = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2999) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
        end

        // take held high: one ready cycle per problem, long enough for problem_id to wrap
        @(negedge clk); take = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            entropy_in = ($urandom_range(0, 1) == 1);
        end
        take = 1'b0;
        @(negedge clk);
        chk("pid_wrap", 0, wrap_seen[0], 1);
        chk("pid_wrap", 4, wrap_seen[4], 1);
        chk("pid_wrap", 1, wrap_seen[1], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
